// File: rtl/cdma_axil_wr_slave.sv
`default_nettype none
// ============================================================================
// Module      : cdma_axil_wr_slave
// Description : AXI4-Lite write responder for the CDMA configuration
//               registers (SA, DA, BTT). AW and W are captured
//               independently. The register write and the B response both
//               happen on the edge where the two halves first meet. A
//               valid BTT write issues a one-cycle start pulse to the DMA
//               datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module cdma_axil_wr_slave #(
  parameter int BTT_W  = 26,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic              dma_busy,
  output logic [31:0]       src_addr,
  output logic [31:0]       dst_addr,
  output logic [BTT_W-1:0]  btt,
  output logic              start
);

  // Word offsets (byte offset >> 2) of the implemented registers
  localparam logic [ADDR_W-3:0] c_OFF_SA  = (ADDR_W-2)'(32'h18 >> 2);
  localparam logic [ADDR_W-3:0] c_OFF_DA  = (ADDR_W-2)'(32'h20 >> 2);
  localparam logic [ADDR_W-3:0] c_OFF_BTT = (ADDR_W-2)'(32'h28 >> 2);
  localparam logic [1:0]        c_OKAY    = 2'b00;
  localparam logic [1:0]        c_SLVERR  = 2'b10;

  logic              r_live;      // low only during the reset cycle(s)
  logic              r_aw_full;
  logic              r_w_full;
  logic [ADDR_W-3:0] r_aw_off;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_start;
  logic [31:0]       r_src;
  logic [31:0]       r_dst;
  logic [BTT_W-1:0]  r_btt;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_commit;
  logic [ADDR_W-3:0] w_off;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [31:0]       w_btt_ext;
  logic [31:0]       w_sa_merge;
  logic [31:0]       w_da_merge;
  logic [31:0]       w_btt_merge;
  logic [BTT_W-1:0]  w_btt_new;
  logic              w_sel_sa;
  logic              w_sel_da;
  logic              w_sel_btt;
  logic              w_btt_ok;
  logic              w_unused;

  // Byte-lane merge of new data into an existing 32-bit value
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // Readies depend on registered state only, so there is no valid->ready path
  assign awready  = r_live & ~r_aw_full & ~r_bvalid;
  assign wready   = r_live & ~r_w_full  & ~r_bvalid;
  assign bvalid   = r_bvalid;
  assign bresp    = r_bresp;
  assign start    = r_start;
  assign src_addr = r_src;
  assign dst_addr = r_dst;
  assign btt      = r_btt;

  // Handshake detection, operand selection (held or live) and decode
  always_comb begin
    w_aw_hs   = awvalid & awready;
    w_w_hs    = wvalid & wready;
    w_commit  = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
    w_off     = r_aw_full ? r_aw_off : awaddr[ADDR_W-1:2];
    w_data    = r_w_full ? r_wdata : wdata;
    w_strb    = r_w_full ? r_wstrb : wstrb;
    w_btt_ext = '0;
    w_btt_ext[BTT_W-1:0] = r_btt;
    w_sa_merge  = f_merge(r_src, w_data, w_strb);
    w_da_merge  = f_merge(r_dst, w_data, w_strb);
    w_btt_merge = f_merge(w_btt_ext, w_data, w_strb);
    w_btt_new   = w_btt_merge[BTT_W-1:0];
    w_sel_sa    = (w_off == c_OFF_SA);
    w_sel_da    = (w_off == c_OFF_DA);
    w_sel_btt   = (w_off == c_OFF_BTT);
    w_btt_ok    = ~dma_busy & (w_strb != 4'b0000) & (w_btt_new != '0);
  end

  // Address bits below the word boundary and merge bits above BTT_W are
  // intentionally dropped
  assign w_unused = &{1'b0, awaddr[1:0], w_btt_merge};

  // Readiness flag and AW/W capture; flags clear when the write commits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_live    <= 1'b0;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_aw_off  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_aw_hs) r_aw_off <= awaddr[ADDR_W-1:2];
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_full <= 1'b1;
        if (w_w_hs)  r_w_full  <= 1'b1;
      end
    end
  end

  // B channel and start pulse; start tracks the first bvalid cycle only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= c_OKAY;
      r_start  <= 1'b0;
    end else begin
      r_start <= w_commit & w_sel_btt & w_btt_ok;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_sel_sa | w_sel_da | (w_sel_btt & w_btt_ok)) ? c_OKAY : c_SLVERR;
      end else if (r_bvalid & bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Register file update on commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src <= '0;
      r_dst <= '0;
      r_btt <= '0;
    end else if (w_commit) begin
      if (w_sel_sa)               r_src <= w_sa_merge;
      if (w_sel_da)               r_dst <= w_da_merge;
      if (w_sel_btt && w_btt_ok)  r_btt <= w_btt_new;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdma_axil_wr_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdma_axil_wr_slave
// Description : Scoreboard bench for cdma_axil_wr_slave. The driver pushes
//               expected responses from a register-level model; a monitor
//               pops and compares them when bvalid rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdma_axil_wr_slave;

  localparam int BTT_W  = 26;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic              dma_busy;
  logic [31:0]       src_addr;
  logic [31:0]       dst_addr;
  logic [BTT_W-1:0]  btt;
  logic              start;

  cdma_axil_wr_slave #(.BTT_W(BTT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dma_busy(dma_busy),
    .src_addr(src_addr), .dst_addr(dst_addr), .btt(btt), .start(start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       bresp;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [BTT_W-1:0] btt;
    logic             start;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference register contents
  logic [31:0]      m_src = '0;
  logic [31:0]      m_dst = '0;
  logic [BTT_W-1:0] m_btt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  // Apply one write to the reference registers and return the expected response
  function automatic exp_t model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                                       input logic [3:0] s, input logic busy);
    exp_t        e;
    logic [31:0] nv;
    logic [31:0] mask;
    e.bresp = 2'b10;
    e.start = 1'b0;
    mask    = (BTT_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << BTT_W) - 32'd1);
    case (a & 10'h3FC)
      10'h018: begin m_src = byte_merge(m_src, d, s); e.bresp = 2'b00; end
      10'h020: begin m_dst = byte_merge(m_dst, d, s); e.bresp = 2'b00; end
      10'h028: begin
        nv = byte_merge(32'(m_btt), d, s) & mask;
        if (!busy && nv != 0 && s != 0) begin
          m_btt   = nv[BTT_W-1:0];
          e.bresp = 2'b00;
          e.start = 1'b1;
        end
      end
      default: ;
    endcase
    e.src = m_src;
    e.dst = m_dst;
    e.btt = m_btt;
    return e;
  endfunction

  // Monitor: compare at the first bvalid cycle, police the hold phase
  initial begin
    logic       prev_bv;
    logic [1:0] held_resp;
    exp_t       e;
    prev_bv   = 1'b0;
    held_resp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_bv = 1'b0;
      end else begin
        if (bvalid && !prev_bv) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bvalid: got bvalid=1 expected no response at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            check("bresp", 32'(bresp), 32'(e.bresp));
            check("src_addr", src_addr, e.src);
            check("dst_addr", dst_addr, e.dst);
            check("btt", 32'(btt), 32'(e.btt));
            check("start_at_b", 32'(start), 32'(e.start));
          end
          held_resp = bresp;
        end else begin
          check("start_idle", 32'(start), 32'd0);
          if (bvalid) check("bresp_stable", 32'(bresp), 32'(held_resp));
        end
        if (bvalid) check("readies_low_in_b", 32'({awready, wready}), 32'd0);
        prev_bv = bvalid;
      end
    end
  end

  // One complete write: AW/W with independent delays, then B with a bready delay
  task automatic do_txn(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic busy, input int aw_dly, input int w_dly, input int b_dly);
    exp_t e;
    bit   aw_done, w_done, aw_hs, w_hs;
    int   cyc;
    aw_done = 0;
    w_done  = 0;
    cyc     = 0;
    @(negedge clk);
    dma_busy = busy;
    e = model_write(a, d, s, busy);
    sb_q.push_back(e);
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = a;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = d;
      wstrb   = s;
      if (aw_done) check("awready_after_aw", 32'(awready), 32'd0);
      if (w_done)  check("wready_after_w", 32'(wready), 32'd0);
      #1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk);
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      @(negedge clk);
      cyc++;
      if (cyc > 60) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: got no AW/W acceptance expected within 60 cycles");
        awvalid = 0;
        wvalid  = 0;
        return;
      end
    end
    awvalid = 0;
    wvalid  = 0;
    check("b_latency", 32'(bvalid), 32'd1);
    for (int i = 0; i < b_dly; i++) begin
      bready = 0;
      @(negedge clk);
      check("bvalid_hold", 32'(bvalid), 32'd1);
    end
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
    check("bvalid_clear", 32'(bvalid), 32'd0);
    check("readies_back", 32'({awready, wready}), 32'd3);
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [31:0]       rd;
    logic [3:0]        rs;
    int                k;
    rst = 1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; dma_busy = 0;
    repeat (3) @(negedge clk);
    check("reset_readies", 32'({awready, wready}), 32'd0);
    check("reset_b", 32'({bvalid, bresp, start}), 32'd0);
    check("reset_regs", src_addr | dst_addr | 32'(btt), 32'd0);
    rst = 0;
    @(negedge clk);
    check("readies_after_reset", 32'({awready, wready}), 32'd3);

    // Directed cases
    do_txn(10'h018, 32'h8000_1000, 4'hF, 0, 0, 0, 0);
    do_txn(10'h020, 32'h9000_0000, 4'hF, 0, 3, 0, 0);
    do_txn(10'h028, 32'd20,        4'hF, 0, 0, 0, 4);
    do_txn(10'h028, 32'd20,        4'hF, 1, 0, 0, 0);
    do_txn(10'h028, 32'd33,        4'hF, 1, 1, 0, 1);
    do_txn(10'h028, 32'd0,         4'hF, 0, 0, 2, 0);
    do_txn(10'h028, 32'd55,        4'h0, 0, 0, 0, 0);
    do_txn(10'h03C, 32'h0000_1234, 4'hF, 0, 0, 0, 0);
    do_txn(10'h018, 32'h1111_2222, 4'hF, 0, 0, 0, 0);
    do_txn(10'h018, 32'hAABB_CCDD, 4'h3, 0, 2, 1, 2);
    check("partial_sa", src_addr, 32'h1111_CCDD);
    do_txn(10'h02B, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 4);
      case (k)
        0: ra = 10'h018 | 10'($urandom_range(0, 3));
        1: ra = 10'h020 | 10'($urandom_range(0, 3));
        2, 3: ra = 10'h028 | 10'($urandom_range(0, 3));
        default: begin
          ra = 10'($urandom_range(0, 1023));
          while ((ra & 10'h3FC) == 10'h018 || (ra & 10'h3FC) == 10'h020 ||
                 (ra & 10'h3FC) == 10'h028)
            ra = 10'($urandom_range(0, 1023));
        end
      endcase
      case ($urandom_range(0, 3))
        0: rd = 32'd0;
        1: rd = 32'($urandom_range(1, 255));
        default: rd = $urandom;
      endcase
      rs = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      do_txn(ra, rd, rs, ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset after an AW handshake with W still outstanding
    do_txn(10'h020, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0);
    @(negedge clk);
    awaddr = 10'h018; awvalid = 1;
    #1 check("aw_ready_pre_reset", 32'(awready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    m_src = '0; m_dst = '0; m_btt = '0;
    check("midrst_readies", 32'({awready, wready}), 32'd0);
    check("midrst_b", 32'({bvalid, bresp, start}), 32'd0);
    check("midrst_regs", src_addr | dst_addr | 32'(btt), 32'd0);
    rst = 0;
    @(negedge clk);
    check("midrst_readies_back", 32'({awready, wready}), 32'd3);
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1;
    @(posedge clk);
    @(negedge clk);
    wvalid = 0;
    for (int i = 0; i < 6; i++) begin
      check("w_alone_no_b", 32'(bvalid), 32'd0);
      @(negedge clk);
    end
    check("w_alone_no_write", src_addr, 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/cdma_axil_wr_slave.md
Name: cdma_axil_wr_slave

Overview:
AXI4-Lite write-channel responder that accepts CDMA configuration writes: source address, destination address and byte length. It captures AW and W independently, commits the write to an internal register file and returns a B response. A valid byte-length write emits a one-cycle start pulse toward the DMA datapath. It sits between the CDMA control master and the DMA engine core.

Parameters:
BTT_W, 26, width of the bytes-to-transfer register (1..32)
ADDR_W, 10, AXI-Lite address width

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
awaddr  input  ADDR_W  write address
awvalid  input  1  AW valid
awready  output  1  AW ready
wdata  input  32  write data
wstrb  input  4  byte strobes
wvalid  input  1  W valid
wready  output  1  W ready
bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
bvalid  output  1  B valid
bready  input  1  B ready
dma_busy  input  1  DMA engine transfer in progress
src_addr  output  32  SA register, offset 0x18
dst_addr  output  32  DA register, offset 0x20
btt  output  BTT_W  BTT register, offset 0x28
start  output  1  one-cycle transfer kick

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: awready=0, wready=0, bvalid=0, bresp=00, start=0; src_addr, dst_addr and btt are 0; capture flags aw_full and w_full are 0. Readies go to 1 on the first cycle after reset deasserts.
- awready = !aw_full & !bvalid. wready = !w_full & !bvalid. Both are registered or derived from registered state only, with no combinational path from the valid inputs.
- AW handshake (awvalid & awready) latches awaddr and sets aw_full. W handshake latches wdata and wstrb and sets w_full. AW and W may arrive in either order, with any gap, or in the same cycle.
- Commit: at the edge where AW and W are both available (each either already held or handshaking this cycle), the following happen on that edge:
  - the register write is performed;
  - bresp is set and bvalid=1;
  - aw_full and w_full are cleared.
  - Latency: AW and W arriving together at edge N give bvalid=1 in cycle N+1.
- Decode uses awaddr[ADDR_W-1:2]; awaddr[1:0] are ignored.
  - 0x18 updates SA per byte strobe and returns OKAY.
  - 0x20 updates DA per byte strobe and returns OKAY.
  - 0x28 (BTT): the strobed merge is truncated to BTT_W bits.
    - If dma_busy=1, or the merged value is 0, or wstrb=0: SLVERR, btt unchanged, no start.
    - Otherwise: btt updated, OKAY, and start=1 for exactly the cycle in which bvalid first rises.
  - Any other offset: SLVERR, no state change.
  - wstrb=0 to SA or DA: OKAY, no change.
- Response: bvalid holds with a stable bresp until bready=1. At the edge where bvalid & bready, bvalid clears; readies reassert in the following cycle. There is at most one outstanding transaction, and no new AW or W is accepted while bvalid=1.
- start never asserts for more than one cycle. It is independent of bready timing.
- dma_busy is sampled only in the commit cycle.
- Reset mid-transaction (captured flags set or bvalid high): everything returns to reset values. The pending write is discarded and no start is issued.

Test Plan:
- AW 0x18 and W 0x8000_1000 (wstrb=F) in the same cycle, bready=1 -> bvalid in the next cycle with bresp=00; src_addr=0x8000_1000; start stays 0.
- W 0x9000_0000 first, AW 0x20 three cycles later -> wready=0 while waiting; dst_addr=0x9000_0000; bresp=00.
- AW 0x28, W 20, dma_busy=0, bready held low for 4 cycles -> btt=20; start high for exactly 1 cycle; bvalid held 4 cycles; AW/W readies stay 0 until one cycle after bready.
- BTT write of 20 with dma_busy=1, then BTT write of 0 -> both give bresp=10; btt unchanged; start never asserts.
- AW 0x3C with data 0x1234 -> bresp=10; SA, DA and BTT unchanged. Partial write wstrb=4'b0011, data 0xAABB_CCDD to SA=0x1111_2222 -> SA=0x1111_CCDD.
- Assert rst one cycle after the AW handshake (no W yet) -> all outputs reset; a subsequent W alone produces no bvalid.
